// File: rtl/mmio_button_led_hub.sv
// Memory-mapped button/LED hub: per-channel debounce, a button-press event FIFO
// and per-channel LED modes (off, on, one-shot flash, blink).
module mmio_button_led_hub #(
    parameter int          NUM_CH          = 4,
    parameter logic [11:0] BASE_ADDR       = 12'd7,
    parameter int          DEBOUNCE_CYCLES = 500000,
    parameter int          FIFO_DEPTH      = 8,
    parameter int          FLASH_CYCLES    = 12500000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [11:0]       addr,
    input  logic              wren,
    input  logic              rden,
    input  logic [31:0]       data_in,
    output logic [31:0]       data_out,
    output logic              hit,
    input  logic [NUM_CH-1:0] buttons,
    output logic [NUM_CH-1:0] leds
);

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int FW = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [DW-1:0] DEB_MAX   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [FW-1:0] FLASH_MAX = FW'(FLASH_CYCLES - 1);

    typedef enum logic {IDLE = 1'b0, TIMED = 1'b1} led_state_t;

    logic [11:0] offset;
    logic        sel_event, sel_led, sel_status, sel_flush;
    logic        led_wr, flush, status_rd, pop_req;
    logic        unused_bits;

    assign offset      = addr - BASE_ADDR;
    assign hit         = (offset < 12'd4);
    assign sel_event   = hit && (offset[1:0] == 2'd0);
    assign sel_led     = hit && (offset[1:0] == 2'd1);
    assign sel_status  = hit && (offset[1:0] == 2'd2);
    assign sel_flush   = hit && (offset[1:0] == 2'd3);
    assign led_wr      = wren && sel_led && (data_in[7:0] < 8'(NUM_CH));
    assign flush       = wren && sel_flush;
    assign status_rd   = rden && !wren && sel_status;
    assign unused_bits = ^data_in[31:10];

    logic [NUM_CH-1:0]         sync1, sync2, deb, armed, rise;
    logic [1:0]                sync_fill;
    logic [NUM_CH-1:0][DW-1:0] db_cnt;

    // A channel is armed only once it has been seen released after reset, so a
    // button held through reset cannot raise an event.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1     <= '0;
            sync2     <= '0;
            sync_fill <= '0;
            deb       <= '0;
            armed     <= '0;
            db_cnt    <= '0;
        end else begin
            sync1     <= buttons;
            sync2     <= sync1;
            sync_fill <= {sync_fill[0], 1'b1};
            for (int i = 0; i < NUM_CH; i++) begin
                if (sync_fill[1] && !sync2[i])
                    armed[i] <= 1'b1;
                if (sync2[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DEB_MAX) begin
                    deb[i]    <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DW'(1);
                end
            end
        end
    end

    always_comb begin
        rise = '0;
        for (int i = 0; i < NUM_CH; i++)
            rise[i] = armed[i] && sync2[i] && !deb[i] && (db_cnt[i] == DEB_MAX);
    end

    logic [NUM_CH-1:0] pending, grant_mask;
    logic              grant_any;
    logic [7:0]        grant_ch;
    logic [7:0]        fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [7:0]        count;
    logic              overflow, empty, full, do_push, do_pop, drop;

    always_comb begin
        grant_any  = 1'b0;
        grant_ch   = '0;
        grant_mask = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (pending[i] && !grant_any) begin
                grant_any     = 1'b1;
                grant_ch      = 8'(i);
                grant_mask[i] = 1'b1;
            end
        end
    end

    assign empty   = (count == 8'd0);
    assign full    = (count == 8'(FIFO_DEPTH));
    assign pop_req = rden && !wren && sel_event && !empty;
    assign do_pop  = pop_req;
    assign do_push = grant_any && !flush && (!full || do_pop);
    assign drop    = grant_any && !flush && full && !do_pop;

    // The granted channel leaves the pending set whether it was stored or dropped.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            pending  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            pending <= (pending & ~grant_mask) | rise;
            if (do_push)
                wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (do_push && !do_pop)
                count <= count + 8'd1;
            else if (do_pop && !do_push)
                count <= count - 8'd1;
            if (drop)
                overflow <= 1'b1;
            else if (status_rd)
                overflow <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push)
            fifo_mem[wr_ptr] <= grant_ch;
    end

    logic [7:0] deb_ext;

    always_comb begin
        deb_ext             = '0;
        deb_ext[NUM_CH-1:0] = deb;
        data_out            = '0;
        if (sel_event && !empty)
            data_out = {1'b1, 23'b0, fifo_mem[rd_ptr]};
        else if (sel_status)
            data_out = {15'b0, overflow, deb_ext, count};
    end

    led_state_t [NUM_CH-1:0]   led_state, led_state_nx;
    logic [NUM_CH-1:0][FW-1:0] led_cnt, led_cnt_nx;
    logic [NUM_CH-1:0]         blink, blink_nx, led_nx;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++)
                led_state[i] <= IDLE;
            led_cnt <= '0;
            blink   <= '0;
            leds    <= '0;
        end else begin
            led_state <= led_state_nx;
            led_cnt   <= led_cnt_nx;
            blink     <= blink_nx;
            leds      <= led_nx;
        end
    end

    // A write to a channel always reloads its timer; TIMED expiry either ends a
    // flash or toggles a blink.
    always_comb begin
        led_state_nx = led_state;
        led_cnt_nx   = led_cnt;
        blink_nx     = blink;
        led_nx       = leds;
        for (int i = 0; i < NUM_CH; i++) begin
            if (led_wr && (data_in[7:0] == 8'(i))) begin
                led_cnt_nx[i] = FLASH_MAX;
                blink_nx[i]   = data_in[8];
                case (data_in[9:8])
                    2'b00: begin led_nx[i] = 1'b0; led_state_nx[i] = IDLE;  end
                    2'b01: begin led_nx[i] = 1'b1; led_state_nx[i] = IDLE;  end
                    default: begin led_nx[i] = 1'b1; led_state_nx[i] = TIMED; end
                endcase
            end else if (led_state[i] == TIMED) begin
                if (led_cnt[i] == '0) begin
                    if (blink[i]) begin
                        led_nx[i]     = !leds[i];
                        led_cnt_nx[i] = FLASH_MAX;
                    end else begin
                        led_nx[i]       = 1'b0;
                        led_state_nx[i] = IDLE;
                    end
                end else begin
                    led_cnt_nx[i] = led_cnt[i] - FW'(1);
                end
            end
        end
    end

endmodule
